// File: rtl/multicycle_cpu_pkg.sv
// Shared types and constants for the multicycle RV32I-subset CPU.
// The optional MUL instruction is enabled by defining MULTICYCLE_CPU_MUL_EN.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [31:0] ECALL_INSTR = 32'h00000073;

    function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_type_t imm_type);
        case (imm_type)
            IMM_I:   gen_imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   gen_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   gen_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   gen_imm = {ir[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: gen_imm = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_cpu_alu.sv
// Combinational ALU for the multicycle CPU; MUL is only built when
// MULTICYCLE_CPU_MUL_EN is defined.
module mc_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = 32'h0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
`ifdef MULTICYCLE_CPU_MUL_EN
            ALU_MUL:  result = a * b;
`else
            ALU_MUL:  result = 32'h0;
`endif
            default:  result = 32'h0;
        endcase
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I-subset CPU: FETCH/DECODE/EXECUTE/MEM/WB with an absorbing HALT.
// Define MULTICYCLE_CPU_MUL_EN to make the MUL encoding legal.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 32,
    parameter int          DMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IMEM_DEPTH-1:0][31:0]  initial_instructions,
    input  logic [31:0][31:0]            initial_register_values,
    output logic [31:0]                  pc_out_check,
    output logic [2:0]                   state_check,
    output logic [31:0][31:0]            register_check,
    output logic [DMEM_DEPTH-1:0][31:0]  dmem_check,
    output logic                         instr_retired,
    output logic                         halted,
    output logic [31:0]                  cycle_count,
    output logic [31:0]                  instret_count
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] aluout_q, aluout_d, cycle_q, cycle_d, instret_q, instret_d;
    logic [31:0][31:0] regs_q, regs_d;
    logic [DMEM_DEPTH-1:0][31:0] dmem_q, dmem_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic legal, is_ecall, is_load, is_store, is_branch, is_jal, is_lui;
    imm_type_t imm_type;
    alu_op_t alu_op;
    logic [31:0] alu_a, alu_b, alu_result, target;
    logic br_taken, exec_fault;
    logic [DMEM_AW-1:0] dmem_idx;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Decode is driven straight from IR, so it is stable from DECODE onwards.
    always_comb begin
        legal     = 1'b0;
        imm_type  = IMM_NONE;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_lui    = 1'b0;
        is_ecall  = (ir_q == ECALL_INSTR);
        case (funct3)
            3'b000: begin
                if (opcode == OPC_OP && funct7 == 7'b0100000)      alu_op = ALU_SUB;
                else if (opcode == OPC_OP && funct7 == 7'b0000001) alu_op = ALU_MUL;
                else                                               alu_op = ALU_ADD;
            end
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
`ifdef MULTICYCLE_CPU_MUL_EN
                if (funct7 == 7'b0000001 && funct3 == 3'b000) legal = 1'b1;
`endif
            end
            OPC_OP_IMM: begin
                imm_type = IMM_I;
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
            end
            OPC_LOAD:   begin imm_type = IMM_I; is_load  = 1'b1; legal = (funct3 == 3'b010); end
            OPC_STORE:  begin imm_type = IMM_S; is_store = 1'b1; legal = (funct3 == 3'b010); end
            OPC_BRANCH: begin
                imm_type  = IMM_B;
                is_branch = 1'b1;
                legal     = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OPC_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; legal = 1'b1; end
            OPC_LUI:    begin imm_type = IMM_U; is_lui = 1'b1; legal = 1'b1; end
            default:    legal = 1'b0;
        endcase
    end

    // JAL reuses the ALU to form the link value PC+4; LUI adds its immediate to zero.
    assign alu_a = is_jal ? pc_q : (is_lui ? 32'h0 : a_q);
    assign alu_b = is_jal ? 32'd4 : ((opcode == OPC_OP) ? b_q : imm_q);

    mc_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (is_alu_add_only() ? ALU_ADD : alu_op),
        .result (alu_result)
    );

    function automatic logic is_alu_add_only();
        is_alu_add_only = is_load || is_store || is_jal || is_lui;
    endfunction

    assign target     = pc_q + imm_q;
    assign br_taken   = is_branch && ((a_q == b_q) ^ funct3[0]);
    assign exec_fault = !legal || is_ecall ||
                        ((is_load || is_store) && alu_result[1:0] != 2'b00) ||
                        ((is_jal || br_taken) && target[1:0] != 2'b00);
    assign dmem_idx   = aluout_q[DMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (exec_fault)               state_d = S_HALT;
                else if (is_load || is_store) state_d = S_MEM;
                else if (is_branch)           state_d = S_FETCH;
                else                          state_d = S_WB;
            end
            S_MEM:     state_d = is_load ? S_WB : S_FETCH;
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_HALT;
        endcase
    end

    always_comb begin
        state_check   = state_q;
        halted        = (state_q == S_HALT);
        instr_retired = !reset &&
                        ((state_q == S_EXECUTE && is_branch && !exec_fault) ||
                         (state_q == S_MEM && is_store) ||
                         (state_q == S_WB));
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        aluout_d  = aluout_q;
        regs_d    = regs_q;
        dmem_d    = dmem_q;
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'b0, instr_retired};
        case (state_q)
            S_FETCH:  ir_d = initial_instructions[pc_q[IMEM_AW+1:2]];
            S_DECODE: begin
                a_d   = regs_q[rs1];
                b_d   = regs_q[rs2];
                imm_d = gen_imm(ir_q, imm_type);
            end
            S_EXECUTE: begin
                aluout_d = alu_result;
                if (is_branch && !exec_fault) pc_d = br_taken ? target : pc_q + 32'd4;
            end
            S_MEM: begin
                if (is_store) begin
                    dmem_d[dmem_idx] = b_q;
                    pc_d             = pc_q + 32'd4;
                end
            end
            S_WB: begin
                if (rd != 5'd0) regs_d[rd] = is_load ? dmem_q[dmem_idx] : aluout_q;
                pc_d = is_jal ? target : pc_q + 32'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            imm_q     <= 32'h0;
            aluout_q  <= 32'h0;
            cycle_q   <= 32'h0;
            instret_q <= 32'h0;
            regs_q    <= initial_register_values;
            regs_q[0] <= 32'h0;
            dmem_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            aluout_q  <= aluout_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            regs_q    <= regs_d;
            dmem_q    <= dmem_d;
        end
    end

    assign pc_out_check   = pc_q;
    assign register_check = regs_q;
    assign dmem_check     = dmem_q;
    assign cycle_count    = cycle_q;
    assign instret_count  = instret_q;

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter IMEM_DEPTH, default 32: instruction words; power of two, at least 4.
REQ-002 Parameter DMEM_DEPTH, default 32: data words; power of two, at least 4.
REQ-003 Parameter RESET_PC, default 32'h0: PC loaded on reset; word-aligned.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 initial_instructions  input  32 x IMEM_DEPTH  instruction ROM contents.
REQ-007 initial_register_values  input  32 x 32  register values loaded on reset; entry 0 ignored.
REQ-008 pc_out_check  output  32  current PC.
REQ-009 state_check  output  3  current FSM state encoding.
REQ-010 register_check  output  32 x 32  architectural registers; x0 reads 0.
REQ-011 dmem_check  output  32 x DMEM_DEPTH  data memory contents.
REQ-012 instr_retired  output  1  one-cycle pulse in the final state of each completed instruction.
REQ-013 halted  output  1  high while in HALT.
REQ-014 cycle_count, instret_count  output  32 each  cycles since reset, and instructions retired since reset.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WB and HALT.
REQ-016 FETCH SHALL latch rom[pc[log2(IMEM_DEPTH)+1:2]] into IR; the index wraps modulo IMEM_DEPTH.
REQ-017 DECODE SHALL latch rs1/rs2 into A/B and the decoded immediate into IMM.
REQ-018 EXECUTE SHALL compute the ALU result into ALUOUT.
REQ-019 Supported ops SHALL be ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; their immediate forms ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; and LW, SW, BEQ, BNE, JAL, LUI.
REQ-020 Shift amount SHALL be b[4:0]; SLT is signed and SLTU unsigned; all arithmetic wraps modulo 2^32.
REQ-021 Latencies SHALL be: ALU, LUI and JAL 4 cycles (F,D,E,WB); LW 5 cycles (F,D,E,M,WB); SW 4 cycles (F,D,E,M); BEQ/BNE 3 cycles (F,D,E).
REQ-022 PC SHALL update once per instruction, in its final state: PC+4 by default, PC+imm for a taken branch or JAL.
REQ-023 JAL SHALL write the old PC+4 into rd.
REQ-024 Writes to x0 SHALL be discarded.
REQ-025 LW/SW address SHALL be rs1+imm, word index addr[log2(DMEM_DEPTH)+1:2], wrapping modulo DMEM_DEPTH.
REQ-026 SW SHALL write the memory in the MEM cycle; LW SHALL write rd in WB.
REQ-027 ECALL (32'h00000073) SHALL enter HALT from EXECUTE without retiring.
REQ-028 Any unsupported encoding SHALL enter HALT from EXECUTE without retiring.
REQ-029 A misaligned LW/SW address (addr[1:0]!=0) SHALL enter HALT from EXECUTE without retiring.
REQ-030 A misaligned branch/JAL target SHALL enter HALT from EXECUTE without retiring.
REQ-031 HALT SHALL be absorbing until reset: PC, registers, memory and instret_count frozen; cycle_count keeps counting.
REQ-032 Both counters SHALL wrap at 2^32.
REQ-033 instret_count SHALL increment in the same cycle instr_retired is high.

Reset
REQ-034 Reset SHALL win over all other activity, including mid-instruction and in HALT.
REQ-035 Reset values SHALL be: PC=RESET_PC, state=FETCH, IR/A/B/ALUOUT=0, both counters=0, instr_retired=0, halted=0.
REQ-036 Reset SHALL load the registers from initial_register_values (x0=0) and clear dmem to 0.

Configuration
REQ-037 With macro MULTICYCLE_CPU_MUL_EN defined, MUL (opcode 0110011, funct3 000, funct7 0000001) SHALL write the low 32 bits of rs1*rs2 with 4-cycle latency.
REQ-038 Without MULTICYCLE_CPU_MUL_EN, that encoding SHALL be illegal and enter HALT.

Structure
REQ-039 Package cpu_pkg SHALL hold alu_op_t, state_t, the opcode constants, the immediate-type enum and the ECALL constant.
REQ-040 The ALU SHALL be the sub-module mc_alu (a, b, alu_op in; result out); the FSM, decode and memories stay in multicycle_cpu.

Verification
REQ-041 x1=5, x2=7; ADD x3,x1,x2; ECALL -> x3=12 after 4 cycles; instret_count=1; halted at cycle 7.
REQ-042 ADDI x1,x0,-1; SLTU x2,x0,x1; SLT x3,x0,x1 -> x1=32'hFFFFFFFF, x2=1, x3=0.
REQ-043 x1=8, x2=32'hDEADBEEF; SW x2,4(x1); LW x3,4(x1) -> dmem[3]=32'hDEADBEEF, x3 equal; the LW takes 5 cycles.
REQ-044 x1=x2=3; BEQ x1,x2,+8 skips the next ADDI -> PC goes 0 to 8 after 3 cycles; the skipped rd is unchanged.
REQ-045 JAL x1,-4 at PC 4 -> x1=8, PC=0; writing x0 via ADDI x0,x0,9 leaves x0=0.
REQ-046 Reset asserted in the MEM cycle of a SW -> dmem unchanged; PC=RESET_PC and state FETCH one cycle later; with and without MUL_EN, MUL 6*7 gives 42 or HALT respectively.
